dac_spi_tx: RTL and testbench
=============================

# dac_spi_tx

Serial DAC transmitter that consumes the 8-bit samples produced by the truncation stage (`trunc`, 22→8 bits) and shifts each one out to an external 12-bit SPI DAC. The DAC uses a 16-bit frame with SYNC framing. The block is the last stage of the filter datapath before the board pins. It owns the SCLK generation, the frame formatting and a valid/ready handshake toward the upstream stage.

## Interface
- `CLK_DIV`, default 2: system clocks per SCLK half-period; legal range ≥1.
- `DATA_W`, default 8: input sample width; fixed at 8 in this design.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `data_in` in 8: unsigned sample from `trunc`.
- `data_valid` in 1: `data_in` is valid this cycle.
- `ready` out 1: the block accepts a sample this cycle.
- `overrun` out 1: one-cycle pulse when `data_valid` is high while `ready` is low; that sample is dropped.
- `sclk` out 1: SPI clock to the DAC; idles high.
- `sync_n` out 1: frame select, active low; idles high.
- `sdata` out 1: serial data, MSB first.

## Operation
- **Frame format (16 bits, MSB first):** `{2'b00 don't-care, 2'b00 mode=normal, data_in[7:0], 4'b0000}`. The 8-bit sample is left-aligned into the 12-bit DAC code.
- **FSM states:** IDLE, SHIFT, QUIET.
- **IDLE**
  - `ready`=1, `sync_n`=1, `sclk`=1, `sdata`=0.
  - On `data_valid`&&`ready`: latch the frame into a 16-bit shift register, clear the divider and the bit counter, and go to SHIFT.
- **SHIFT**
  - `sync_n`=0 and `ready`=0.
  - `sdata` = shift register MSB.
  - A divider counts 0..CLK_DIV-1. At each terminal count `sclk` toggles.
  - On a falling toggle (1→0) the DAC samples. On the following rising toggle (0→1) the register shifts left by one and the bit counter increments.
  - After the 16th rising toggle: go to QUIET.
- **QUIET**
  - `sync_n`=1, `sclk`=1, `sdata`=0, `ready`=0.
  - Lasts CLK_DIV cycles, which covers the DAC's minimum SYNC-high time. Then go to IDLE.
- **Overrun**
  - `data_valid` while in SHIFT or QUIET pulses `overrun` for that cycle.
  - The sample is not stored and the current frame is unaffected.
  - A `data_valid` held over several busy cycles pulses `overrun` on every one of those cycles.
- **Reset**
  - Asserting `reset` at any point, including mid-frame, immediately forces IDLE.
  - Outputs go to `sync_n`=1, `sclk`=1, `sdata`=0, `ready`=1, `overrun`=0.
  - Counters and the shift register clear.
  - The partial frame is abandoned; the DAC ignores it because SYNC rises before the 16th falling edge.

## Timing
- **Acceptance:** sample accepted on the rising edge at cycle k, when `ready`=1 and `data_valid`=1.
- **k+1:** `sync_n`=0, `ready`=0, `sdata`=frame bit 15, `sclk`=1.
- **First falling edge:** `sclk` falls at k+1+CLK_DIV.
- **Bit update:** `sdata` changes only while `sclk` rises, so it is stable for CLK_DIV cycles before and after each falling edge.
- **Per frame:** 16 falling edges; the SHIFT phase is 32·CLK_DIV cycles.
- **End of frame:** `sync_n` returns to 1 at k+1+32·CLK_DIV; `ready` returns to 1 at k+1+33·CLK_DIV.
- **Throughput:** maximum one sample per 1+33·CLK_DIV cycles. For CLK_DIV=2 that is 67 cycles.
- **Outputs:** `sclk`, `sync_n` and `sdata` come straight from flops, so they are glitch-free.
- **Combinational paths:** `ready` and `overrun` are combinational from state and `data_valid` only.

## Structure
- **Shared package/header `dac_pkg`:**
  - state encodings `ST_IDLE`, `ST_SHIFT`, `ST_QUIET`;
  - `FRAME_W`=16;
  - `MODE_NORMAL`=2'b00;
  - `PAD_LSB`=4.
- **Sub-module `sclk_div`:** parameterised by CLK_DIV. Provides the divider counter and emits `rise_tick`/`fall_tick` strobes with an enable and a synchronous clear.
- **Top:** `dac_spi_tx` contains the FSM, the shift register and the bit counter.

## Test plan
- **Reset values:** assert `reset` for 3 cycles, CLK_DIV=2 → `sync_n`=1, `sclk`=1, `sdata`=0, `ready`=1, `overrun`=0.
- **Frame contents:** `data_in`=8'hA5 accepted at cycle k →
  - bits captured on the 16 `sclk` falling edges are `0000_1010_0101_0000`;
  - `sync_n` is low from k+1 through k+64;
  - `ready` is back to 1 at k+67.
- **Back-to-back:** hold `data_valid`=1 with 8'hFF then 8'h00 →
  - second frame starts the cycle after `ready` rises;
  - the 8'hFF frame captures `0000_1111_1111_0000`;
  - `overrun` pulses on every busy cycle.
- **Overrun:** single `data_valid` pulse with 8'h3C at cycle k+10 during a frame →
  - `overrun`=1 at k+10 only;
  - the frame in flight is unchanged;
  - no 8'h3C frame follows.
- **Reset mid-frame:** assert `reset` after the 7th falling edge →
  - `sync_n`=1 and `sclk`=1 in the same cycle;
  - the next accepted sample 8'h81 produces a complete, correct frame.
- **Drive from `trunc`:** CLK_DIV=1 with the 100-sample stimulus set driven through `trunc` →
  - each frame is 33 cycles plus 1 acceptance cycle;
  - the decoded DAC codes equal the `trunc` outputs shifted left by 4.

Source files
------------

// File: rtl/dac_pkg.sv
// Shared definitions for the serial DAC transmitter: FSM encoding, frame
// geometry and the frame formatting helper.
package dac_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_QUIET = 2'd2
   } state_t;

   localparam int         FRAME_W     = 16;
   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam int         PAD_LSB     = 4;

   // Build the 16-bit DAC frame: two don't-care bits, mode bits, the sample
   // left-aligned into the 12-bit code, and zero padding below it.
   function automatic logic [FRAME_W-1:0] make_frame(input logic [7:0] sample);
      return {2'b00, MODE_NORMAL, sample, {PAD_LSB{1'b0}}};
   endfunction

endpackage

// File: rtl/sclk_div.sv
// SCLK generator: counts CLK_DIV system clocks per SCLK half-period and
// toggles the SCLK phase at each terminal count. The strobes flag the
// toggle that is about to happen so the caller can act on the same edge.
module sclk_div #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic clr_i,
   output logic rise_tick_o,
   output logic fall_tick_o,
   output logic sclk_o
);

   localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          phase_q, phase_d;
   logic          tick;

   assign tick        = en_i && (cnt_q == TERM);
   assign rise_tick_o = tick && !phase_q;
   assign fall_tick_o = tick && phase_q;
   assign sclk_o      = phase_q;

   // Next divider count and SCLK phase; clear parks SCLK high at count 0.
   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (clr_i) begin
         cnt_d   = '0;
         phase_d = 1'b1;
      end else if (en_i) begin
         if (tick) begin
            cnt_d   = '0;
            phase_d = !phase_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Divider and phase registers; SCLK idles high out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

endmodule

// File: rtl/dac_spi_tx.sv
// Serial DAC transmitter: accepts one 8-bit sample at a time and shifts it
// out MSB first inside a 16-bit SYNC-framed SPI transfer, followed by a
// SYNC-high quiet gap before the next sample can be taken.
//
// Handshake: a sample transfers on a rising edge where data_valid and ready
// are both high. ready is high only in IDLE; data_valid while ready is low
// drops that sample and raises overrun for that same cycle.
module dac_spi_tx
   import dac_pkg::*;
#(
   parameter int CLK_DIV = 2,
   parameter int DATA_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_valid,
   output logic              ready,
   output logic              overrun,
   output logic              sclk,
   output logic              sync_n,
   output logic              sdata
);

   localparam int            QW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] QTERM = QW'(CLK_DIV - 1);

   state_t               state_q, state_d;
   logic [FRAME_W-1:0]   sr_q, sr_d;
   logic [3:0]           bit_cnt_q, bit_cnt_d;
   logic                 last_q, last_d;
   logic [QW-1:0]        quiet_cnt_q, quiet_cnt_d;
   logic                 sync_n_q, sync_n_d;
   logic                 div_en, div_clr;
   logic                 rise_tick, fall_tick;

   sclk_div #(.CLK_DIV(CLK_DIV)) u_sclk_div (
      .clk         (clk),
      .reset       (reset),
      .en_i        (div_en),
      .clr_i       (div_clr),
      .rise_tick_o (rise_tick),
      .fall_tick_o (fall_tick),
      .sclk_o      (sclk)
   );

   assign ready   = (state_q == ST_IDLE);
   assign overrun = data_valid && (state_q != ST_IDLE);
   assign sync_n  = sync_n_q;
   // After sixteen shifts the register holds zeros, so the MSB is already
   // 0 in QUIET and IDLE without any output gating.
   assign sdata   = sr_q[FRAME_W-1];

   // FSM next state plus shift register, bit counter and quiet timer updates.
   // last_q marks that the 16th DAC sampling edge has passed; the rising
   // edge after it closes the frame.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      last_d      = last_q;
      quiet_cnt_d = quiet_cnt_q;
      sync_n_d    = sync_n_q;
      div_en      = 1'b0;
      div_clr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (data_valid) begin
               sr_d      = make_frame(data_in);
               bit_cnt_d = '0;
               last_d    = 1'b0;
               div_clr   = 1'b1;
               sync_n_d  = 1'b0;
               state_d   = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            div_en = 1'b1;
            if (fall_tick && (bit_cnt_q == 4'd15)) begin
               last_d = 1'b1;
            end
            if (rise_tick) begin
               sr_d      = {sr_q[FRAME_W-2:0], 1'b0};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (last_q) begin
                  last_d      = 1'b0;
                  sync_n_d    = 1'b1;
                  quiet_cnt_d = '0;
                  state_d     = ST_QUIET;
               end
            end
         end
         ST_QUIET: begin
            if (quiet_cnt_q == QTERM) begin
               state_d = ST_IDLE;
            end else begin
               quiet_cnt_d = quiet_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any frame in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         last_q      <= 1'b0;
         quiet_cnt_q <= '0;
         sync_n_q    <= 1'b1;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         last_q      <= last_d;
         quiet_cnt_q <= quiet_cnt_d;
         sync_n_q    <= sync_n_d;
      end
   end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: instance 0 runs with CLK_DIV=2 for the directed
// frame, back-to-back, overrun and mid-frame reset cases; instance 1 runs
// with CLK_DIV=1 for a 100-sample stream of truncated 22-bit values.
module tb_dac_spi_tx;

   localparam int D0 = 2;
   localparam int D1 = 1;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] din   [2];
   logic       valid [2];
   logic       ready_w   [2];
   logic       overrun_w [2];
   logic       sclk_w    [2];
   logic       sync_w    [2];
   logic       sdata_w   [2];

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   // Timing model: cycles elapsed since acceptance (0 = idle) and the frame.
   int          mdl_t     [2] = '{0, 0};
   logic [15:0] mdl_frame [2] = '{16'h0, 16'h0};

   // Frame decoder state: bits captured on SCLK falling edges.
   logic        prev_sclk [2] = '{1'b1, 1'b1};
   logic        prev_sync [2] = '{1'b1, 1'b1};
   logic [15:0] cap       [2] = '{16'h0, 16'h0};
   int          nbits     [2] = '{0, 0};
   int          aborts    = 0;
   logic [15:0] rx0_q [$];
   logic [15:0] rx1_q [$];
   logic [15:0] exp_q [$];

   dac_spi_tx #(.CLK_DIV(D0), .DATA_W(8)) u_dut0 (
      .clk        (clk),
      .reset      (reset),
      .data_in    (din[0]),
      .data_valid (valid[0]),
      .ready      (ready_w[0]),
      .overrun    (overrun_w[0]),
      .sclk       (sclk_w[0]),
      .sync_n     (sync_w[0]),
      .sdata      (sdata_w[0])
   );

   dac_spi_tx #(.CLK_DIV(D1), .DATA_W(8)) u_dut1 (
      .clk        (clk),
      .reset      (reset),
      .data_in    (din[1]),
      .data_valid (valid[1]),
      .ready      (ready_w[1]),
      .overrun    (overrun_w[1]),
      .sclk       (sclk_w[1]),
      .sync_n     (sync_w[1]),
      .sdata      (sdata_w[1])
   );

   // Clock
   always #5 clk = ~clk;

   function automatic int div_of(input int i);
      return (i == 0) ? D0 : D1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int c = 0; c < n; c++) tick();
   endtask

   // One-cycle valid pulse; returns in the first cycle after acceptance.
   task automatic send(input int i, input logic [7:0] d);
      valid[i] = 1'b1;
      din[i]   = d;
      tick();
      valid[i] = 1'b0;
   endtask

   task automatic pop_check(input int i, input string name, input logic [15:0] req);
      logic [15:0] got;
      for (int c = 0; c < 200; c++) begin
         if (((i == 0) ? rx0_q.size() : rx1_q.size()) != 0) break;
         tick();
      end
      if (((i == 0) ? rx0_q.size() : rx1_q.size()) == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: no frame received, expected %0h", name, req);
      end else begin
         got = (i == 0) ? rx0_q.pop_front() : rx1_q.pop_front();
         check(name, {16'h0, got}, {16'h0, req});
      end
   endtask

   // Model: advance the per-instance frame timer from the timing rules.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            mdl_t[i] <= 0;
         end else if (mdl_t[i] == 0) begin
            if (valid[i]) begin
               mdl_t[i]     <= 1;
               mdl_frame[i] <= 16'(din[i]) << 4;
            end
         end else if (mdl_t[i] == 33 * div_of(i)) begin
            mdl_t[i] <= 0;
         end else begin
            mdl_t[i] <= mdl_t[i] + 1;
         end
      end
   end

   // Compare every cycle against the model, then decode SPI frames.
   always @(negedge clk) begin
      int d, t, h;
      logic e_rdy, e_ovr, e_sclk, e_sync, e_sd;
      for (int i = 0; i < 2; i++) begin
         d      = div_of(i);
         t      = mdl_t[i];
         e_rdy  = 1'b1;
         e_ovr  = 1'b0;
         e_sclk = 1'b1;
         e_sync = 1'b1;
         e_sd   = 1'b0;
         h      = 0;
         if (!reset && t != 0) begin
            e_rdy = 1'b0;
            e_ovr = valid[i];
            if (t <= 32 * d) begin
               h      = (t - 1) / d;
               e_sync = 1'b0;
               e_sclk = ((h % 2) == 0);
               e_sd   = mdl_frame[i][15 - h / 2];
            end
         end
         check($sformatf("ready%0d", i),   {31'h0, ready_w[i]},   {31'h0, e_rdy});
         check($sformatf("overrun%0d", i), {31'h0, overrun_w[i]}, {31'h0, e_ovr});
         check($sformatf("sclk%0d", i),    {31'h0, sclk_w[i]},    {31'h0, e_sclk});
         check($sformatf("sync_n%0d", i),  {31'h0, sync_w[i]},    {31'h0, e_sync});
         check($sformatf("sdata%0d", i),   {31'h0, sdata_w[i]},   {31'h0, e_sd});

         if (!reset && !sync_w[i] && prev_sclk[i] && !sclk_w[i]) begin
            cap[i]   <= {cap[i][14:0], sdata_w[i]};
            nbits[i] <= nbits[i] + 1;
         end
         if (!prev_sync[i] && sync_w[i]) begin
            if (nbits[i] == 16) begin
               if (i == 0) rx0_q.push_back(cap[i]);
               else        rx1_q.push_back(cap[i]);
            end else begin
               aborts <= aborts + 1;
            end
            nbits[i] <= 0;
         end
         prev_sclk[i] <= sclk_w[i];
         prev_sync[i] <= sync_w[i];
      end
   end

   // Directed stimulus with hand-computed expectations.
   initial begin
      int          ovr_cnt;
      logic [31:0] raw;
      logic [7:0]  s;
      logic [15:0] got;

      valid[0] = 1'b0; valid[1] = 1'b0;
      din[0]   = 8'h00; din[1]  = 8'h00;

      // Reset values
      ticks(3);
      check("rst_sync_n",  {31'h0, sync_w[0]},    32'h1);
      check("rst_sclk",    {31'h0, sclk_w[0]},    32'h1);
      check("rst_sdata",   {31'h0, sdata_w[0]},   32'h0);
      check("rst_ready",   {31'h0, ready_w[0]},   32'h1);
      check("rst_overrun", {31'h0, overrun_w[0]}, 32'h0);
      reset = 1'b0;
      ticks(2);

      // Single frame 8'hA5
      send(0, 8'hA5);
      check("a5_sync_k1",  {31'h0, sync_w[0]},  32'h0);
      check("a5_ready_k1", {31'h0, ready_w[0]}, 32'h0);
      check("a5_sclk_k1",  {31'h0, sclk_w[0]},  32'h1);
      ticks(63);
      check("a5_sync_k64", {31'h0, sync_w[0]},  32'h0);
      tick();
      check("a5_sync_k65", {31'h0, sync_w[0]},  32'h1);
      tick();
      check("a5_ready_k66", {31'h0, ready_w[0]}, 32'h0);
      tick();
      check("a5_ready_k67", {31'h0, ready_w[0]}, 32'h1);
      pop_check(0, "a5_frame", 16'h0A50);
      ticks(3);

      // Back-to-back 8'hFF then 8'h00 with data_valid held
      valid[0] = 1'b1;
      din[0]   = 8'hFF;
      tick();
      din[0]  = 8'h00;
      ovr_cnt = 0;
      for (int j = 0; j < 67; j++) begin
         if (overrun_w[0]) ovr_cnt++;
         if (j < 66) tick();
      end
      tick();
      valid[0] = 1'b0;
      check("b2b_overrun_count", ovr_cnt, 66);
      check("b2b_second_start",  {31'h0, sync_w[0]}, 32'h0);
      pop_check(0, "b2b_ff_frame", 16'h0FF0);
      pop_check(0, "b2b_00_frame", 16'h0000);
      ticks(5);

      // Overrun pulse with 8'h3C during a 8'h5A frame
      send(0, 8'h5A);
      ticks(9);
      valid[0] = 1'b1;
      din[0]   = 8'h3C;
      #1;
      check("ovr_pulse_k10", {31'h0, overrun_w[0]}, 32'h1);
      tick();
      valid[0] = 1'b0;
      #1;
      check("ovr_clear_k11", {31'h0, overrun_w[0]}, 32'h0);
      pop_check(0, "ovr_frame", 16'h05A0);
      ticks(100);
      check("ovr_no_3c_frame", rx0_q.size(), 0);
      check("ovr_idle_ready",  {31'h0, ready_w[0]}, 32'h1);

      // Reset after the 7th falling edge of a 8'hC3 frame
      send(0, 8'hC3);
      ticks(27);
      check("mid_sclk_low", {31'h0, sclk_w[0]}, 32'h0);
      reset = 1'b1;
      #1;
      check("mid_rst_sync_n", {31'h0, sync_w[0]},  32'h1);
      check("mid_rst_sclk",   {31'h0, sclk_w[0]},  32'h1);
      check("mid_rst_sdata",  {31'h0, sdata_w[0]}, 32'h0);
      check("mid_rst_ready",  {31'h0, ready_w[0]}, 32'h1);
      ticks(2);
      reset = 1'b0;
      ticks(2);
      check("mid_abort_count", aborts, 1);
      check("mid_no_frame",    rx0_q.size(), 0);
      send(0, 8'h81);
      pop_check(0, "mid_81_frame", 16'h0810);
      ticks(5);

      // 100 truncated samples through the CLK_DIV=1 instance
      for (int i = 0; i < 100; i++) begin
         if (i == 0)      raw = 32'h0;
         else if (i == 1) raw = 32'h003F_FFFF;
         else if (i == 2) raw = 32'h0020_0000;
         else             raw = (i * 32'd1234567 + 32'd98765) & 32'h003F_FFFF;
         s = raw[21:14];
         exp_q.push_back(16'(s) << 4);
         check($sformatf("trunc_ready_%0d", i), {31'h0, ready_w[1]}, 32'h1);
         send(1, s);
         ticks(33);
         if (rx1_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL trunc_frame_%0d: no frame received", i);
            void'(exp_q.pop_front());
         end else begin
            got = rx1_q.pop_front();
            check($sformatf("trunc_frame_%0d", i), {16'h0, got}, {16'h0, exp_q.pop_front()});
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   // Watchdog
   initial begin
      #1_000_000;
      n_bad++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
